act_requant: RTL and testbench

- Downstream neighbour of the vector FMA stage. Consumes its OUTPUT_WIDTH-wide signed accumulator vectors and produces DATA_WIDTH-wide activations for the next layer's val_in.
- Per lane: rounding arithmetic right shift (requantization), optional ReLU, then saturation to DATA_WIDTH.
- Two-stage pipeline with valid/ready handshake on both sides and full backpressure support.

---
 rtl/act_requant_if.sv | 35 +++
 rtl/act_requant.sv | 126 ++++++++++++
 tb/tb_act_requant.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/act_requant_if.sv
// act_requant bus: accumulator vectors in, activations out,
// plus the saturation counter controls.
interface act_requant_if #(
  parameter int VECTOR_WIDTH = 4,
  parameter int ACC_WIDTH    = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int SHIFT_WIDTH  = 4,
  parameter int CNT_WIDTH    = 16
) ();
  logic                                  in_valid;
  logic                                  in_ready;
  logic [VECTOR_WIDTH-1:0][ACC_WIDTH-1:0] acc_in;
  logic [SHIFT_WIDTH-1:0]                shift_in;
  logic                                  relu_en;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [VECTOR_WIDTH-1:0][DATA_WIDTH-1:0] act_out;
  logic [VECTOR_WIDTH-1:0]               sat_flag;
  logic                                  sat_clr;
  logic [CNT_WIDTH-1:0]                  sat_count;

  modport master (
    output in_valid, acc_in, shift_in, relu_en,
    output out_ready, sat_clr,
    input  in_ready, out_valid, act_out,
    input  sat_flag, sat_count
  );

  modport slave (
    input  in_valid, acc_in, shift_in, relu_en,
    input  out_ready, sat_clr,
    output in_ready, out_valid, act_out,
    output sat_flag, sat_count
  );
endinterface

// File: rtl/act_requant.sv
// Requantize FMA accumulators: round shift, ReLU, saturate.
// Define ACT_LEAKY_EN for a 1/8 leaky slope under relu_en.
module act_requant #(
  parameter int VECTOR_WIDTH = 4,
  parameter int ACC_WIDTH    = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int SHIFT_WIDTH  = 4,
  parameter int CNT_WIDTH    = 16
) (
  input logic          clk,
  input logic          rst,
  act_requant_if.slave bus
);
  localparam int RW = ACC_WIDTH + 1;
  typedef logic signed [RW-1:0] r_t;
  localparam r_t MAXV = r_t'(2**(DATA_WIDTH-1) - 1);
  localparam r_t MINV = ~MAXV;

  logic                  s1_valid;
  logic                  s1_relu;
  r_t                    s1_r   [VECTOR_WIDTH];
  r_t                    s1_nxt [VECTOR_WIDTH];
  logic [DATA_WIDTH:0]   s2_nxt [VECTOR_WIDTH];
  logic                  s1_adv;
  logic                  in_acc;
  logic                  out_fire;

  // Round-half-up shift; extra bit keeps +max from wrapping.
  function automatic r_t rnd(
    input logic [ACC_WIDTH-1:0]   a,
    input logic [SHIFT_WIDTH-1:0] sh
  );
    r_t x;
    r_t b;
    x = {a[ACC_WIDTH-1], a};
    b = '0;
    if (int'(sh) >= ACC_WIDTH) return {RW{a[ACC_WIDTH-1]}};
    if (sh != '0) b = r_t'(1) << (sh - SHIFT_WIDTH'(1));
    return (x + b) >>> sh;
  endfunction

  // Returns {saturated, value}.
  function automatic logic [DATA_WIDTH:0] sat(
    input r_t   r,
    input logic relu
  );
    r_t   v;
    logic f;
    v = r;
    f = 1'b0;
    if (relu && v[RW-1]) begin
`ifdef ACT_LEAKY_EN
      v = v >>> 3;
`else
      v = '0;
`endif
    end
    if (v > MAXV) begin
      v = MAXV;
      f = 1'b1;
    end else if (v < MINV) begin
      v = MINV;
      f = 1'b1;
    end
    return {f, v[DATA_WIDTH-1:0]};
  endfunction

  assign s1_adv       = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s1_adv;
  assign in_acc       = bus.in_valid && bus.in_ready;
  assign out_fire     = bus.out_valid && bus.out_ready;

  // Per-lane datapath for both stages.
  always_comb begin
    for (int i = 0; i < VECTOR_WIDTH; i++) begin
      s1_nxt[i] = rnd(bus.acc_in[i], bus.shift_in);
      s2_nxt[i] = sat(s1_r[i], s1_relu);
    end
  end

  // Stage 1: capture rounded values on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_relu  <= 1'b0;
      for (int i = 0; i < VECTOR_WIDTH; i++)
        s1_r[i] <= '0;
    end else begin
      if (bus.in_ready) s1_valid <= bus.in_valid;
      if (in_acc) begin
        s1_relu <= bus.relu_en;
        for (int i = 0; i < VECTOR_WIDTH; i++)
          s1_r[i] <= s1_nxt[i];
      end
    end
  end

  // Stage 2: clamp into the output register; hold on stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.act_out   <= '0;
      bus.sat_flag  <= '0;
    end else if (s1_adv) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        for (int i = 0; i < VECTOR_WIDTH; i++) begin
          bus.act_out[i]  <= s2_nxt[i][DATA_WIDTH-1:0];
          bus.sat_flag[i] <= s2_nxt[i][DATA_WIDTH];
        end
      end
    end
  end

  // Count delivered vectors with any saturated lane; clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.sat_count <= '0;
    end else if (bus.sat_clr) begin
      bus.sat_count <= '0;
    end else if (out_fire && |bus.sat_flag
                 && bus.sat_count != '1) begin
      bus.sat_count <= bus.sat_count + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_act_requant.sv
// Bench for act_requant: directed cases plus random traffic
// against an arithmetic model with a per-cycle scoreboard.
module tb_act_requant;
  logic clk = 1'b0;
  logic rst = 1'b1;

  act_requant_if bus ();

  act_requant u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][7:0] act;
    logic [3:0]      flag;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   mcount = 0;
  bit   stall = 0;
  logic [31:0] pact;
  logic [3:0]  pflag;

  task automatic chk(input string n,
                     input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, got, exp);
    end
  endtask

  function automatic int fdiv(input int a, input int d);
    int r;
    r = a / d;
    if ((a % d) != 0 && a < 0) r = r - 1;
    return r;
  endfunction

  // Requantize one lane from the arithmetic definition.
  function automatic void model(input int acc, input int sh,
                                input bit relu,
                                output int v, output bit f);
    int r;
    int d;
    if (sh >= 16) r = (acc < 0) ? -1 : 0;
    else if (sh == 0) r = acc;
    else begin
      d = 2 ** sh;
      r = fdiv(acc + d / 2, d);
    end
    if (relu && r < 0) begin
`ifdef ACT_LEAKY_EN
      r = fdiv(r, 8);
`else
      r = 0;
`endif
    end
    f = 1'b0;
    if (r > 127) begin v = 127; f = 1'b1; end
    else if (r < -128) begin v = -128; f = 1'b1; end
    else v = r;
  endfunction

  // Scoreboard: predicts what the coming edge transfers.
  always @(negedge clk) begin
    exp_t e;
    int   v;
    bit   f;
    if (rst) begin
      q.delete();
      mcount = 0;
      stall  = 0;
    end else begin
      if (stall) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_act", bus.act_out, pact);
        chk("hold_flag", bus.sat_flag, pflag);
      end
      chk("sat_count", bus.sat_count, mcount);
      chk("in_ready", bus.in_ready,
          !(q.size() == 2 && !bus.out_ready));
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          e = q.pop_front();
          chk("act_out", bus.act_out, e.act);
          chk("sat_flag", bus.sat_flag, e.flag);
          if (bus.sat_clr) mcount = 0;
          else if (|e.flag && mcount < 65535)
            mcount = mcount + 1;
        end
      end else if (bus.sat_clr) begin
        mcount = 0;
      end
      if (bus.in_valid && bus.in_ready) begin
        for (int i = 0; i < 4; i++) begin
          model(int'($signed(bus.acc_in[i])),
                int'(bus.shift_in), bus.relu_en, v, f);
          e.act[i]  = 8'(v);
          e.flag[i] = f;
        end
        q.push_back(e);
      end
      stall = bus.out_valid && !bus.out_ready;
      pact  = bus.act_out;
      pflag = bus.sat_flag;
    end
  end

  task automatic set_vec(input int a);
    for (int i = 0; i < 4; i++) bus.acc_in[i] = 16'(a);
  endtask

  task automatic put(input int a, input int sh, input bit relu);
    int n;
    bit ok;
    set_vec(a);
    bus.shift_in = 4'(sh);
    bus.relu_en  = relu;
    bus.in_valid = 1'b1;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = bus.in_ready;
      if (!ok) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    if (!ok) chk("put_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_next(input string n, input int v,
                             input bit f);
    @(negedge clk);
    chk({n, "_lat1"}, bus.out_valid, 0);
    @(negedge clk);
    chk({n, "_valid"}, bus.out_valid, 1);
    chk({n, "_act"}, $signed(bus.act_out[0]), v);
    chk({n, "_flag"}, bus.sat_flag[0], f);
    @(posedge clk);
    #1;
  endtask

  function automatic int rnd_lane();
    case ($urandom % 4)
      0: return ($urandom % 2) ? 32767 : -32768;
      1: return int'($urandom_range(600)) - 300;
      default: return int'($signed(16'($urandom)));
    endcase
  endfunction

  initial begin
    int v;
    bit f;
    int relu_exp;
    bus.in_valid  = 1'b0;
    bus.acc_in    = '0;
    bus.shift_in  = '0;
    bus.relu_en   = 1'b0;
    bus.out_ready = 1'b0;
    bus.sat_clr   = 1'b0;

`ifdef ACT_LEAKY_EN
    relu_exp = -7;
`else
    relu_exp = 0;
`endif

    model(1000, 3, 0, v, f);
    chk("m_basic", v, 125);
    model(-5, 1, 0, v, f);
    chk("m_rnd_neg", v, -2);
    model(32767, 1, 0, v, f);
    chk("m_max", v, 127);
    chk("m_max_f", f, 1);
    model(-300, 0, 0, v, f);
    chk("m_neg_sat", v, -128);
    model(-50, 0, 1, v, f);
    chk("m_relu", v, relu_exp);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_act", bus.act_out, 0);
    chk("rst_cnt", bus.sat_count, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;

    put(1000, 3, 0);
    expect_next("basic", 125, 0);
    put(-5, 1, 0);
    expect_next("rnd_neg", -2, 0);
    put(300, 0, 0);
    expect_next("sat_pos", 127, 1);
    put(-300, 0, 0);
    expect_next("sat_neg", -128, 1);
    @(negedge clk);
    chk("cnt_two", bus.sat_count, 2);
    @(posedge clk);
    #1 bus.sat_clr = 1'b1;
    @(posedge clk);
    #1 bus.sat_clr = 1'b0;
    @(negedge clk);
    chk("cnt_clr", bus.sat_count, 0);
    @(posedge clk);
    #1;
    put(32767, 1, 0);
    expect_next("rnd_max", 127, 1);
    put(-50, 0, 1);
    expect_next("relu", relu_exp, 0);

    bus.out_ready = 1'b0;
    bus.shift_in  = '0;
    bus.relu_en   = 1'b0;
    set_vec(10);
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("bp_a_rdy", bus.in_ready, 1);
    @(posedge clk);
    #1 set_vec(20);
    @(negedge clk);
    chk("bp_b_rdy", bus.in_ready, 1);
    @(posedge clk);
    #1 set_vec(30);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_c_block", bus.in_ready, 0);
      chk("bp_hold", $signed(bus.act_out[0]), 10);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_out_a", $signed(bus.act_out[0]), 10);
    chk("bp_c_rdy", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_out_b", $signed(bus.act_out[0]), 20);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_out_c", $signed(bus.act_out[0]), 30);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_empty", bus.out_valid, 0);

    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    set_vec(300);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 set_vec(-300);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("mid_full", bus.out_valid, 1);
    chk("mid_cnt", bus.sat_count, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_act", bus.act_out, 0);
    chk("arst_cnt", bus.sat_count, 0);
    @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    put(40, 2, 0);
    expect_next("post_rst", 10, 0);

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      bus.in_valid  = ($urandom % 4) != 0;
      bus.out_ready = ($urandom % 3) != 0;
      bus.sat_clr   = ($urandom % 50) == 0;
      bus.shift_in  = 4'($urandom % 16);
      bus.relu_en   = 1'($urandom % 2);
      for (int i = 0; i < 4; i++)
        bus.acc_in[i] = 16'(rnd_lane());
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.sat_clr   = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
